// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring, sign-fixed) unit.
// Latency: 33 cycles from accepting edge to done (1 cycle for divide-by-zero); 35-cycle repeat rate.
// Backpressure: none; start is only sampled in IDLE and ignored while busy is high.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;        // 0 = MULT, 1 = DIV
    logic        qneg_q, qneg_d;    // quotient must be negated
    logic        rneg_q, rneg_d;    // remainder must be negated (dividend < 0)
    logic        dz_q, dz_d;        // operation in flight is a divide by zero
    logic [31:0] m_q, m_d;          // multiplicand, or |divisor|
    logic [31:0] acc_q, acc_d;      // Booth accumulator, or partial remainder
    logic [31:0] mq_q, mq_d;        // multiplier/product low, or dividend/quotient
    logic        q1_q, q1_d;        // Booth q-1 bit
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dzo_q, dzo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] booth_sum;
    logic [32:0] div_shift, div_trial;

    // Next-state, datapath iteration and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        abs_a = src_a[31] ? (32'd0 - src_a) : src_a;
        abs_b = src_b[31] ? (32'd0 - src_b) : src_b;

        // 33-bit add/sub keeps the INT_MIN multiplicand from overflowing the accumulator
        booth_sum = {acc_q[31], acc_q};
        case ({mq_q[0], q1_q})
            2'b01:   booth_sum = {acc_q[31], acc_q} + {m_q[31], m_q};
            2'b10:   booth_sum = {acc_q[31], acc_q} - {m_q[31], m_q};
            default: booth_sum = {acc_q[31], acc_q};
        endcase

        // Partial remainder stays below |divisor| <= 2^31, so the shifted value fits 32 bits
        div_shift = {acc_q, mq_q[31]};
        div_trial = div_shift - {1'b0, m_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    op_d   = op;
                    cnt_d  = 5'd0;
                    acc_d  = 32'd0;
                    q1_d   = 1'b0;
                    qneg_d = src_a[31] ^ src_b[31];
                    rneg_d = src_a[31];
                    dz_d   = op && (src_b == 32'd0);
                    if (op) begin
                        m_d  = abs_b;
                        mq_d = abs_a;
                    end else begin
                        m_d  = src_a;
                        mq_d = src_b;
                    end
                    // Divide by zero skips the iterations; FIX suppresses the result load
                    state_d = (op && (src_b == 32'd0)) ? FIX : RUN;
                end
            end
            RUN: begin
                if (op_q) begin
                    acc_d = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
                    mq_d  = {mq_q[30:0], ~div_trial[32]};
                end else begin
                    acc_d = booth_sum[32:1];
                    mq_d  = {booth_sum[0], mq_q[31:1]};
                    q1_d  = mq_q[0];
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d = 1'b1;
                dzo_d  = dz_q;
                if (!dz_q) begin
                    hi_d = (op_q && rneg_q) ? (32'd0 - acc_q) : acc_q;
                    lo_d = (op_q && qneg_q) ? (32'd0 - mq_q) : mq_q;
                end
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers; reset clears everything including results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            m_q     <= 32'd0;
            acc_q   <= 32'd0;
            mq_q    <= 32'd0;
            q1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products, quotients and timing.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Each comparison is an immediate assertion that counts and reports its own failure.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one start pulse; returns just after the accepting edge with junk on the inputs
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        op    = ~o;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Count edges until done is seen, bounded at 100
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
    endtask

    // Full operation: latency, results, flag, and busy/done release one edge later
    task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_hl, input int exp_lat,
                          input logic exp_dz);
        int lat;
        issue(o, a, b);
        chk({tag, " busy after accept"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " hi/lo"}, {hi_out, lo_out}, exp_hl);
        chk({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        step();
        chk({tag, " busy/done released"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        src_a = 32'd0;
        src_b = 32'd0;
        step();
        step();
        chk("reset busy/done/dz", {61'd0, busy, done, div_zero}, 64'd0);
        chk("reset hi/lo", {hi_out, lo_out}, 64'd0);
        reset = 1'b1;
        step();

        // Multiply cases
        run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 33, 1'b0);
        run_op("mul min*min", 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, 1'b0);
        run_op("mul max*max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 33, 1'b0);

        // Divide cases: {remainder, quotient}
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
        run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
        run_op("div -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 1'b0);

        // Divide by zero: done one edge after accept, previous results kept
        run_op("div 5/0", 1'b1, 32'd5, 32'd0, 64'hFFFFFFFE_0000000E, 1, 1'b1);
        chk("div 5/0 flag cleared", 64'(div_zero), 64'd0);

        // Start presented while done is high must be ignored
        issue(1'b0, 32'd2, 32'd3);
        wait_done(lat);
        chk("mul 2*3 latency", 64'(lat), 64'd33);
        chk("mul 2*3 hi/lo", {hi_out, lo_out}, 64'd6);
        start = 1'b1;
        op    = 1'b0;
        src_a = 32'd5;
        src_b = 32'd5;
        step();
        start = 1'b0;
        chk("start on done ignored busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) pulses++;
        end
        chk("start on done ignored activity", 64'(pulses), 64'd0);
        chk("start on done ignored hi/lo", {hi_out, lo_out}, 64'd6);

        // Start while busy must not disturb the operation in flight
        issue(1'b0, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) step();
        start = 1'b1;
        op    = 1'b1;
        src_a = 32'd100;
        src_b = 32'd0;
        step();
        start = 1'b0;
        wait_done(lat);
        chk("mul 3*4 latency with stray start", 64'(lat + 10), 64'd33);
        chk("mul 3*4 hi/lo", {hi_out, lo_out}, 64'h00000000_0000000C);
        chk("mul 3*4 div_zero", 64'(div_zero), 64'd0);
        step();
        chk("mul 3*4 busy released", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN
        issue(1'b0, 32'd9, 32'd9);
        for (int i = 0; i < 14; i++) step();
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid-run reset busy/done/dz", {61'd0, busy, done, div_zero}, 64'd0);
        chk("mid-run reset hi/lo", {hi_out, lo_out}, 64'd0);
        step();
        step();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) pulses++;
        end
        chk("no activity after reset", 64'(pulses), 64'd0);

        // Unit still works after the abort
        run_op("mul -1*-1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
